// File: rtl/top.sv
// Pairwise Hamming-distance min/max engine.
// Reads N 16-bit operands from data memory dm (big-endian byte pairs at
// core[2i], core[2i+1]), evaluates the Hamming distance of every unordered
// pair (j<k), then writes the minimum to dm.core[64] and the maximum to
// dm.core[65]. N comes from register file RF1.Core[6], clamped to 32.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-high; high holds the start state, low runs
//   done  - high once both results are written, held until the next reset

// Eight-entry 8-bit register file; one sync write port, one comb read port.
module reg_file (
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr,
  output logic [7:0] rdata_c
);
  logic [7:0] Core [0:7];

  always_ff @(posedge clk) begin
    if (we) Core[waddr] <= wdata;
  end

  assign rdata_c = Core[raddr];
endmodule

// 256-byte data memory; four comb read ports and one sync write port.
// Deliberately has no reset so contents survive reset of the engine.
module data_mem (
  input  logic       clk,
  input  logic [7:0] raddr0,
  input  logic [7:0] raddr1,
  input  logic [7:0] raddr2,
  input  logic [7:0] raddr3,
  output logic [7:0] rdata0_c,
  output logic [7:0] rdata1_c,
  output logic [7:0] rdata2_c,
  output logic [7:0] rdata3_c,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);
  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end

  assign rdata0_c = core[raddr0];
  assign rdata1_c = core[raddr1];
  assign rdata2_c = core[raddr2];
  assign rdata3_c = core[raddr3];
endmodule

module top (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam int unsigned NW      = 6;   // operand count, 0..32
  localparam int unsigned IW      = 5;   // operand index, 0..31
  localparam int unsigned DW      = 5;   // distance, 0..16
  localparam int unsigned MAX_OPS = 32;
  localparam logic [7:0]  MIN_ADDR = 8'd64;
  localparam logic [7:0]  MAX_ADDR = 8'd65;

  typedef enum logic [2:0] {
    S_START, S_COMPARE, S_WRMIN, S_WRMAX, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [NW-1:0]  n_q;
  logic [IW-1:0]  j_q, k_q;
  logic [DW-1:0]  min_q, max_q;

  logic [7:0]     rf_rdata_c;
  logic [NW-1:0]  n_sample_c;
  logic [7:0]     rd0_c, rd1_c, rd2_c, rd3_c;
  logic [15:0]    op_j_c, op_k_c;
  logic [DW-1:0]  dist_c;
  logic           last_k_c, last_pair_c;

  logic           mem_we;
  logic [7:0]     mem_waddr, mem_wdata;
  logic           done_d;

  // Operand count source; the FSM never writes the register file.
  reg_file RF1 (
    .clk     (clk),
    .we      (1'b0),
    .waddr   (3'd0),
    .wdata   (8'd0),
    .raddr   (3'd6),
    .rdata_c (rf_rdata_c)
  );

  // Operand j and k byte pairs, stride fixed at 2 bytes per operand.
  data_mem dm (
    .clk      (clk),
    .raddr0   ({2'b00, j_q, 1'b0}),
    .raddr1   ({2'b00, j_q, 1'b1}),
    .raddr2   ({2'b00, k_q, 1'b0}),
    .raddr3   ({2'b00, k_q, 1'b1}),
    .rdata0_c (rd0_c),
    .rdata1_c (rd1_c),
    .rdata2_c (rd2_c),
    .rdata3_c (rd3_c),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata)
  );

  function automatic logic [DW-1:0] popcount16(input logic [15:0] v);
    logic [DW-1:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + DW'(v[i]);
    return c;
  endfunction

  // Counts above 32 saturate so operand reads never reach the result bytes.
  assign n_sample_c  = (rf_rdata_c > 8'(MAX_OPS)) ? NW'(MAX_OPS) : rf_rdata_c[NW-1:0];
  assign op_j_c      = {rd0_c, rd1_c};
  assign op_k_c      = {rd2_c, rd3_c};
  assign dist_c      = popcount16(op_j_c ^ op_k_c);
  assign last_k_c    = ({1'b0, k_q} == (n_q - NW'(1)));
  assign last_pair_c = last_k_c && ({1'b0, j_q} == (n_q - NW'(2)));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_START;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:   state_d = (n_sample_c < NW'(2)) ? S_WRMIN : S_COMPARE;
      S_COMPARE: if (last_pair_c) state_d = S_WRMIN;
      S_WRMIN:   state_d = S_WRMAX;
      S_WRMAX:   state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_START;
    endcase
  end

  // Output logic: result writes and done request.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = 8'd0;
    mem_wdata = 8'd0;
    done_d    = (state_d == S_DONE);
    case (state_q)
      S_WRMIN: begin
        mem_we    = 1'b1;
        mem_waddr = MIN_ADDR;
        mem_wdata = {3'b000, min_q};
      end
      S_WRMAX: begin
        mem_we    = 1'b1;
        mem_waddr = MAX_ADDR;
        mem_wdata = {3'b000, max_q};
      end
      default: ;
    endcase
  end

  // Registered done; clears asynchronously with reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= done_d;
  end

  // Pair indices and running min/max, one pair per COMPARE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q   <= '0;
      j_q   <= '0;
      k_q   <= IW'(1);
      min_q <= DW'(16);
      max_q <= '0;
    end else begin
      case (state_q)
        S_START: begin
          n_q   <= n_sample_c;
          j_q   <= '0;
          k_q   <= IW'(1);
          min_q <= DW'(16);
          max_q <= '0;
        end
        S_COMPARE: begin
          if (dist_c < min_q) min_q <= dist_c;
          if (dist_c > max_q) max_q <= dist_c;
          if (last_k_c) begin
            j_q <= j_q + IW'(1);
            k_q <= j_q + IW'(2);
          end else begin
            k_q <= k_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top.sv
// Directed bench for the pairwise Hamming min/max engine.
module tb_top;
  logic clk;
  logic reset;
  logic done;

  int tests;
  int fails;

  typedef struct {
    string            name;
    logic [7:0]       n;
    logic [31:0][15:0] ops;
    int               exp_min;
    int               exp_max;
    int               exp_lat;
  } vec_t;

  vec_t vecs[9];

  top dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fill_byte(input int a);
    logic [7:0] b;
    b = 8'(a);
    return b ^ 8'h3C;
  endfunction

  function automatic logic [7:0] exp_byte(input vec_t v, input int a);
    if (a < 64) return (a % 2 == 0) ? v.ops[a/2][15:8] : v.ops[a/2][7:0];
    return fill_byte(a);
  endfunction

  // Load memories while reset is held high.
  task automatic load(input vec_t v);
    for (int a = 0; a < 256; a++) dut.dm.core[a] <= exp_byte(v, a);
    dut.dm.core[64] <= 8'hAA;
    dut.dm.core[65] <= 8'h55;
    for (int r = 0; r < 8; r++) dut.RF1.Core[r] <= 8'h00;
    dut.RF1.Core[5] <= 8'd2;
    dut.RF1.Core[6] <= v.n;
    #1;
  endtask

  // Count rising edges after release until done is seen.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_results(input vec_t v, input int lat);
    int bad;
    check({v.name, " latency"}, lat, v.exp_lat);
    check({v.name, " min"}, int'(dut.dm.core[64]), v.exp_min);
    check({v.name, " max"}, int'(dut.dm.core[65]), v.exp_max);
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (a != 64 && a != 65 && dut.dm.core[a] !== exp_byte(v, a)) bad++;
    check({v.name, " untouched bytes"}, bad, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    load(v);
    @(negedge clk);
    reset = 1'b0;
    wait_done(lat);
    check_results(v, lat);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lat;
    int mn, mx, d;
    tests = 0;
    fails = 0;
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      vecs[i].ops = '0;
    end
    vecs[0].name = "all_zero";   vecs[0].n = 8'd32;
    vecs[0].exp_min = 0;  vecs[0].exp_max = 0;  vecs[0].exp_lat = 499;
    vecs[1].name = "one_ffff";   vecs[1].n = 8'd32; vecs[1].ops[1] = 16'hFFFF;
    vecs[1].exp_min = 0;  vecs[1].exp_max = 16; vecs[1].exp_lat = 499;
    vecs[2].name = "n2";         vecs[2].n = 8'd2;
    vecs[2].ops[0] = 16'h00FF;   vecs[2].ops[1] = 16'h0F0F;
    vecs[2].exp_min = 8;  vecs[2].exp_max = 8;  vecs[2].exp_lat = 4;
    vecs[3].name = "n1";         vecs[3].n = 8'd1;  vecs[3].ops[0] = 16'h1234;
    vecs[3].exp_min = 16; vecs[3].exp_max = 0;  vecs[3].exp_lat = 3;
    vecs[4].name = "n0";         vecs[4].n = 8'd0;  vecs[4].ops[1] = 16'hFFFF;
    vecs[4].exp_min = 16; vecs[4].exp_max = 0;  vecs[4].exp_lat = 3;
    vecs[5].name = "n40_clamp";  vecs[5].n = 8'd40; vecs[5].ops[0] = 16'h0001;
    vecs[5].exp_min = 0;  vecs[5].exp_max = 1;  vecs[5].exp_lat = 499;
    // Distances 2, 4, 2.
    vecs[6].name = "n3";         vecs[6].n = 8'd3;
    vecs[6].ops[1] = 16'h0003;   vecs[6].ops[2] = 16'h000F;
    vecs[6].exp_min = 2;  vecs[6].exp_max = 4;  vecs[6].exp_lat = 6;
    // Distances 1, 15, 16, 14, 15, 1.
    vecs[7].name = "n4";         vecs[7].n = 8'd4;
    vecs[7].ops[0] = 16'h8000;   vecs[7].ops[1] = 16'h8001;
    vecs[7].ops[2] = 16'hFFFF;   vecs[7].ops[3] = 16'h7FFF;
    vecs[7].exp_min = 1;  vecs[7].exp_max = 16; vecs[7].exp_lat = 9;
    // Random operands, expectations from a software reference.
    vecs[8].name = "random32";   vecs[8].n = 8'd32;
    for (int i = 0; i < 32; i++) vecs[8].ops[i] = 16'($urandom);
    mn = 16; mx = 0;
    for (int j = 0; j < 32; j++)
      for (int k = j + 1; k < 32; k++) begin
        d = $countones(vecs[8].ops[j] ^ vecs[8].ops[k]);
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
    vecs[8].exp_min = mn; vecs[8].exp_max = mx; vecs[8].exp_lat = 499;

    repeat (2) @(posedge clk);
    #1;
    check("done in reset", int'(done), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset mid-run: no result write, then a clean rerun.
    load(vecs[1]);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort done", int'(done), 0);
    check("abort dm64", int'(dut.dm.core[64]), 8'hAA);
    check("abort dm65", int'(dut.dm.core[65]), 8'h55);
    @(negedge clk);
    reset = 1'b0;
    wait_done(lat);
    check_results(vecs[1], lat);

    // done is held in the terminal state.
    repeat (5) @(posedge clk);
    #1;
    check("done held", int'(done), 1);
    check("held dm64", int'(dut.dm.core[64]), 0);

    // Reset while done drops it without a clock edge, then reruns.
    #2;
    reset = 1'b1;
    #1;
    check("done async drop", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_done(lat);
    check("rerun latency", lat, 499);
    check("rerun max", int'(dut.dm.core[65]), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
